// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive buffer controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    // One start bit, eight data bits, one stop bit.
    localparam int unsigned BITS_PER_CHAR = 10;

    // RTS flow-control state; the encoding equals the o_rts_n level driven.
    typedef enum logic {
        RTS_ON  = 1'b0,
        RTS_OFF = 1'b1
    } rts_state_t;

    // Character-timeout state.
    typedef enum logic [1:0] {
        TO_IDLE  = 2'd0,
        TO_COUNT = 2'd1,
        TO_FIRED = 2'd2
    } to_state_t;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Bundle of receive-side, read-side and status signals of uart_rx_ctrl.
// Latency: n/a (wiring only).
// Backpressure: o_wr_ready / o_rts_n carry the buffer's backpressure.
// Ports: i_rx_dv/i_rx_byte (receiver strobe), o_wr_ready, o_rts_n,
//        i_rd_en/o_rd_data/o_empty/o_level (FWFT read side),
//        o_overrun/i_clr_overrun, i_irq_en/o_irq.
// Modports: slave = the controller, master = whoever drives it.
interface uart_rx_ctrl_if #(
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          i_rx_dv;
    logic [7:0]    i_rx_byte;
    logic          o_wr_ready;
    logic          o_rts_n;
    logic          i_rd_en;
    logic [7:0]    o_rd_data;
    logic          o_empty;
    logic [LW-1:0] o_level;
    logic          o_overrun;
    logic          i_clr_overrun;
    logic          i_irq_en;
    logic          o_irq;

    modport slave (
        input  i_rx_dv, i_rx_byte, i_rd_en, i_clr_overrun, i_irq_en,
        output o_wr_ready, o_rts_n, o_rd_data, o_empty, o_level, o_overrun, o_irq
    );

    modport master (
        output i_rx_dv, i_rx_byte, i_rd_en, i_clr_overrun, i_irq_en,
        input  o_wr_ready, o_rts_n, o_rd_data, o_empty, o_level, o_overrun, o_irq
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through byte FIFO for the UART receive path.
// Latency: write visible on o_rd_data one cycle after the push edge; read is zero-cycle.
// Backpressure: a push while full is accepted only together with a pop (o_wr_ready = !full).
// Ports: i_Clock, rst (async active-low), i_wr_en/i_wr_data, i_rd_en/o_rd_data,
//        o_empty, o_full, o_wr_ready, o_level, o_push/o_pop (accepted ops this cycle).
module uart_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   i_Clock,
    input  logic                   rst,
    input  logic                   i_wr_en,
    input  logic [7:0]             i_wr_data,
    input  logic                   i_rd_en,
    output logic [7:0]             o_rd_data,
    output logic                   o_empty,
    output logic                   o_full,
    output logic                   o_wr_ready,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_push,
    output logic                   o_pop
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_level == LW'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_pop   = i_rd_en & ~w_empty;
    // When full, the slot freed by a same-cycle pop takes the new byte.
    assign w_push  = i_wr_en & (~w_full | i_rd_en);

    // Pointers are exactly AW bits wide, so the increments wrap modulo DEPTH.
    always_ff @(posedge i_Clock or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge i_Clock) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_rd_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign o_empty    = w_empty;
    assign o_full     = w_full;
    assign o_wr_ready = ~w_full;
    assign o_level    = r_level;
    assign o_push     = w_push;
    assign o_pop      = w_pop;
endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive buffer controller: FWFT byte buffer, RTS hysteresis, sticky overrun, interrupt.
// Latency: status outputs register one cycle after the push/pop edge; o_rts_n/o_irq one more.
// Backpressure: o_rts_n throttles the link partner; bytes arriving while full without a pop are dropped.
// Ports: i_Clock, rst (async active-low), bus (uart_rx_ctrl_if.slave: receive, read, status, irq).
// Optional: define UART_RX_TIMEOUT_EN to build the character-timeout FSM (IDLE/COUNT/FIRED);
//           otherwise the timeout term of the interrupt is constant 0.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int RTS_HI       = 12,
    parameter int RTS_LO       = 8,
    parameter int CLKS_PER_BIT = 87,
    parameter int TO_CHARS     = 4
) (
    input  logic          i_Clock,
    input  logic          rst,
    uart_rx_ctrl_if.slave bus
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [LW-1:0] w_level;
    logic [7:0]    w_rd_data;
    logic          w_empty;
    logic          w_full;
    logic          w_wr_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_rts_hi;
    logic          w_rts_lo;
    logic          w_ovr_set;
    logic          w_timeout;

    rts_state_t    r_rts_state;
    logic          r_rts_n;
    logic          r_overrun;
    logic          r_irq;

    uart_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_Clock    (i_Clock),
        .rst        (rst),
        .i_wr_en    (bus.i_rx_dv),
        .i_wr_data  (bus.i_rx_byte),
        .i_rd_en    (bus.i_rd_en),
        .o_rd_data  (w_rd_data),
        .o_empty    (w_empty),
        .o_full     (w_full),
        .o_wr_ready (w_wr_ready),
        .o_level    (w_level),
        .o_push     (w_push),
        .o_pop      (w_pop)
    );

    assign w_rts_hi  = (w_level >= LW'(RTS_HI));
    assign w_rts_lo  = (w_level <= LW'(RTS_LO));
    // A byte is lost only if the buffer is full and nothing leaves this cycle.
    assign w_ovr_set = bus.i_rx_dv & w_full & ~bus.i_rd_en;

    // RTS hysteresis between the high and low watermarks.
    always_ff @(posedge i_Clock or negedge rst) begin
        if (!rst) begin
            r_rts_state <= RTS_ON;
            r_rts_n     <= 1'b0;
        end else begin
            case (r_rts_state)
                RTS_ON: if (w_rts_hi) begin
                    r_rts_state <= RTS_OFF;
                    r_rts_n     <= 1'b1;
                end
                RTS_OFF: if (w_rts_lo) begin
                    r_rts_state <= RTS_ON;
                    r_rts_n     <= 1'b0;
                end
                default: begin
                    r_rts_state <= RTS_ON;
                    r_rts_n     <= 1'b0;
                end
            endcase
        end
    end

    // A new overrun in the clear cycle wins over the clear.
    always_ff @(posedge i_Clock or negedge rst) begin
        if (!rst) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_ovr_set | (r_overrun & ~bus.i_clr_overrun);
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    localparam int unsigned TO_LIMIT = TO_CHARS * BITS_PER_CHAR * CLKS_PER_BIT;
    localparam int          CW       = $clog2(TO_LIMIT);

    to_state_t     r_to_state;
    logic [CW-1:0] r_to_cnt;
    logic          w_activity;

    assign w_activity = w_push | w_pop;

    // r_to_cnt holds the number of idle clocks seen so far in COUNT.
    always_ff @(posedge i_Clock or negedge rst) begin
        if (!rst) begin
            r_to_state <= TO_IDLE;
            r_to_cnt   <= '0;
        end else begin
            case (r_to_state)
                TO_IDLE: if (!w_empty && !w_activity) begin
                    r_to_state <= TO_COUNT;
                    r_to_cnt   <= CW'(1);
                end
                TO_COUNT: begin
                    if (w_activity) begin
                        r_to_cnt <= '0;
                    end else if (w_empty) begin
                        r_to_state <= TO_IDLE;
                        r_to_cnt   <= '0;
                    end else if (r_to_cnt == CW'(TO_LIMIT - 1)) begin
                        r_to_state <= TO_FIRED;
                        r_to_cnt   <= '0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                // Only draining data acknowledges a fired timeout.
                TO_FIRED: if (w_pop || w_empty) begin
                    r_to_state <= TO_IDLE;
                    r_to_cnt   <= '0;
                end
                default: begin
                    r_to_state <= TO_IDLE;
                    r_to_cnt   <= '0;
                end
            endcase
        end
    end

    assign w_timeout = (r_to_state == TO_FIRED);
`else
    logic [31:0] w_unused_cfg;
    logic        w_unused_act;

    assign w_timeout    = 1'b0;
    assign w_unused_cfg = TO_CHARS * BITS_PER_CHAR * CLKS_PER_BIT;
    assign w_unused_act = w_push | w_pop;
`endif

    always_ff @(posedge i_Clock or negedge rst) begin
        if (!rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= bus.i_irq_en & (w_rts_hi | r_overrun | w_timeout);
        end
    end

    assign bus.o_rd_data  = w_rd_data;
    assign bus.o_empty    = w_empty;
    assign bus.o_wr_ready = w_wr_ready;
    assign bus.o_level    = w_level;
    assign bus.o_rts_n    = r_rts_n;
    assign bus.o_overrun  = r_overrun;
    assign bus.o_irq      = r_irq;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl against a queue-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx_ctrl;
    localparam int DEPTH  = 16;
    localparam int RTS_HI = 12;
    localparam int RTS_LO = 8;
    localparam int CPB    = 4;
    localparam int TOC    = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_ctrl_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_ctrl #(
        .DEPTH(DEPTH), .RTS_HI(RTS_HI), .RTS_LO(RTS_LO),
        .CLKS_PER_BIT(CPB), .TO_CHARS(TOC)
    ) dut (
        .i_Clock (clk),
        .rst     (rst_n),
        .bus     (bus)
    );

    // Reference model: buffer contents as a queue plus flag bits.
    logic [7:0] m_q[$];
    bit         m_ov;
    bit         m_rts_n;
    bit         m_irq;
    int         vectors;
    int         miscompares;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1);
    end

    // One clock of stimulus; the model advances by the spec rules for that edge.
    task automatic cycle(input bit dv, input logic [7:0] b, input bit rd, input bit clr, input bit en);
        int sz;
        bit full;
        @(negedge clk);
        bus.i_rx_dv       = dv;
        bus.i_rx_byte     = b;
        bus.i_rd_en       = rd;
        bus.i_clr_overrun = clr;
        bus.i_irq_en      = en;
        @(posedge clk);
        sz    = m_q.size();
        full  = (sz == DEPTH);
        m_irq = en && ((sz >= RTS_HI) || m_ov);
        if (!m_rts_n && sz >= RTS_HI) m_rts_n = 1'b1;
        else if (m_rts_n && sz <= RTS_LO) m_rts_n = 1'b0;
        if (rd && sz > 0) void'(m_q.pop_front());
        if (dv && (!full || rd)) m_q.push_back(b);
        m_ov = (dv && full && !rd) || (m_ov && !clr);
        #1;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ov = 0; m_rts_n = 0; m_irq = 0;
    endtask

    task automatic test_reset();
        bus.i_rx_dv = 0; bus.i_rx_byte = 0; bus.i_rd_en = 0;
        bus.i_clr_overrun = 0; bus.i_irq_en = 0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({bus.o_level, bus.o_empty, bus.o_wr_ready, bus.o_rts_n, bus.o_overrun, bus.o_irq, bus.o_rd_data}
            !== {5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_state: got lvl=%0d emp=%b rdy=%b rts_n=%b ov=%b irq=%b rd=%h, need 0 1 1 0 0 0 00",
                     bus.o_level, bus.o_empty, bus.o_wr_ready, bus.o_rts_n, bus.o_overrun, bus.o_irq, bus.o_rd_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_order();
        logic [7:0] pat [3];
        pat[0] = 8'hA5; pat[1] = 8'h5A; pat[2] = 8'h3C;
        for (int i = 0; i < 3; i++) cycle(1, pat[i], 0, 0, 0);
        vectors++;
        if (bus.o_level !== 5'd3) begin
            miscompares++;
            $display("FAIL order_level3: got %0d need 3", bus.o_level);
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (bus.o_rd_data !== pat[i]) begin
                miscompares++;
                $display("FAIL order_data[%0d]: got %h need %h", i, bus.o_rd_data, pat[i]);
            end
            cycle(0, 8'h00, 1, 0, 0);
            vectors++;
            if (bus.o_level !== 5'(2 - i)) begin
                miscompares++;
                $display("FAIL order_level: got %0d need %0d", bus.o_level, 2 - i);
            end
        end
        vectors++;
        if (bus.o_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL order_empty: got %b need 1", bus.o_empty);
        end
    endtask

    task automatic test_rts();
        for (int i = 0; i < RTS_HI; i++) cycle(1, 8'($urandom), 0, 0, 1);
        vectors++;
        if ({bus.o_level, bus.o_rts_n} !== {5'd12, 1'b0}) begin
            miscompares++;
            $display("FAIL rts_at_12: got lvl=%0d rts_n=%b need 12 0", bus.o_level, bus.o_rts_n);
        end
        cycle(0, 8'h00, 0, 0, 1);
        vectors++;
        if ({bus.o_rts_n, bus.o_irq} !== 2'b11) begin
            miscompares++;
            $display("FAIL rts_off: got rts_n=%b irq=%b need 1 1", bus.o_rts_n, bus.o_irq);
        end
        while (m_q.size() > RTS_LO) begin
            vectors++;
            if (bus.o_rd_data !== m_q[0]) begin
                miscompares++;
                $display("FAIL rts_pop_data: got %h need %h", bus.o_rd_data, m_q[0]);
            end
            cycle(0, 8'h00, 1, 0, 1);
            vectors++;
            if ({bus.o_rts_n, bus.o_irq} !== {m_rts_n, m_irq}) begin
                miscompares++;
                $display("FAIL rts_pop_flags: got rts_n=%b irq=%b need %b %b", bus.o_rts_n, bus.o_irq, m_rts_n, m_irq);
            end
        end
        vectors++;
        if ({bus.o_level, bus.o_rts_n} !== {5'd8, 1'b1}) begin
            miscompares++;
            $display("FAIL rts_at_8: got lvl=%0d rts_n=%b need 8 1", bus.o_level, bus.o_rts_n);
        end
        cycle(0, 8'h00, 0, 0, 0);
        vectors++;
        if (bus.o_rts_n !== 1'b0) begin
            miscompares++;
            $display("FAIL rts_on: got %b need 0", bus.o_rts_n);
        end
        while (m_q.size() > 0) cycle(0, 8'h00, 1, 0, 0);
    endtask

    task automatic test_overrun_full();
        logic [7:0] last;
        for (int i = 0; i < DEPTH; i++) cycle(1, 8'($urandom_range(0, 254)), 0, 0, 0);
        vectors++;
        if ({bus.o_level, bus.o_wr_ready, bus.o_overrun} !== {5'd16, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL full_state: got lvl=%0d rdy=%b ov=%b need 16 0 0", bus.o_level, bus.o_wr_ready, bus.o_overrun);
        end
        cycle(1, 8'hFF, 0, 0, 1);
        vectors++;
        if ({bus.o_level, bus.o_overrun} !== {5'd16, 1'b1}) begin
            miscompares++;
            $display("FAIL overrun_set: got lvl=%0d ov=%b need 16 1", bus.o_level, bus.o_overrun);
        end
        cycle(0, 8'h00, 0, 0, 1);
        vectors++;
        if (bus.o_irq !== m_irq) begin
            miscompares++;
            $display("FAIL overrun_irq: got %b need %b", bus.o_irq, m_irq);
        end
        cycle(0, 8'h00, 0, 1, 0);
        vectors++;
        if (bus.o_overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_clear: got %b need 0", bus.o_overrun);
        end
        cycle(1, 8'hFF, 0, 1, 0);
        vectors++;
        if (bus.o_overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_clear_collide: got %b need 1", bus.o_overrun);
        end
        cycle(0, 8'h00, 0, 1, 0);
        // Full: push 0x11 with a simultaneous pop.
        vectors++;
        if (bus.o_rd_data !== m_q[0]) begin
            miscompares++;
            $display("FAIL full_pushpop_head: got %h need %h", bus.o_rd_data, m_q[0]);
        end
        cycle(1, 8'h11, 1, 0, 0);
        vectors++;
        if ({bus.o_level, bus.o_overrun} !== {5'd16, 1'b0}) begin
            miscompares++;
            $display("FAIL full_pushpop: got lvl=%0d ov=%b need 16 0", bus.o_level, bus.o_overrun);
        end
        last = 8'h00;
        while (m_q.size() > 0) begin
            vectors++;
            if (bus.o_rd_data !== m_q[0]) begin
                miscompares++;
                $display("FAIL full_drain_data: got %h need %h", bus.o_rd_data, m_q[0]);
            end
            last = bus.o_rd_data;
            cycle(0, 8'h00, 1, 0, 0);
        end
        vectors++;
        if (last !== 8'h11) begin
            miscompares++;
            $display("FAIL full_last_entry: got %h need 11", last);
        end
    endtask

    task automatic test_timeout();
        int idle;
        cycle(1, 8'h42, 0, 0, 1);
        for (idle = 0; idle < 30; idle++) cycle(0, 8'h00, 0, 0, 1);
        vectors++;
        if (bus.o_irq !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_early: got irq=%b need 0", bus.o_irq);
        end
        while (bus.o_irq !== 1'b1 && idle < 45) begin
            cycle(0, 8'h00, 0, 0, 1);
            idle++;
        end
`ifdef UART_RX_TIMEOUT_EN
        // 40 idle clocks to fire, plus one for the registered interrupt.
        vectors++;
        if (bus.o_irq !== 1'b1 || idle < 40 || idle > 41) begin
            miscompares++;
            $display("FAIL timeout_fire: got irq=%b after %0d idle clocks need 1 after 40..41", bus.o_irq, idle);
        end
`else
        vectors++;
        if (bus.o_irq !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_disabled: got irq=%b need 0", bus.o_irq);
        end
`endif
        cycle(0, 8'h00, 1, 0, 1);
        cycle(0, 8'h00, 0, 0, 1);
        vectors++;
        if ({bus.o_irq, bus.o_empty} !== 2'b01) begin
            miscompares++;
            $display("FAIL timeout_clear: got irq=%b emp=%b need 0 1", bus.o_irq, bus.o_empty);
        end
    endtask

    task automatic test_random();
        bit dv, rd, clr, en;
        for (int i = 0; i < 400; i++) begin
            dv  = ($urandom_range(0, 99) < ((i < 200) ? 70 : 30));
            rd  = ($urandom_range(0, 99) < ((i < 200) ? 30 : 70));
            clr = ($urandom_range(0, 99) < 10);
`ifdef UART_RX_TIMEOUT_EN
            en  = 1'b0;
`else
            en  = 1'($urandom_range(0, 1));
`endif
            if (m_q.size() > 0) begin
                vectors++;
                if (bus.o_rd_data !== m_q[0]) begin
                    miscompares++;
                    $display("FAIL rand_data @%0d: got %h need %h", i, bus.o_rd_data, m_q[0]);
                end
            end
            cycle(dv, 8'($urandom), rd, clr, en);
            vectors++;
            if ({bus.o_level, bus.o_empty, bus.o_wr_ready, bus.o_rts_n, bus.o_overrun, bus.o_irq} !==
                {5'(m_q.size()), m_q.size() == 0, m_q.size() != DEPTH, m_rts_n, m_ov, m_irq}) begin
                miscompares++;
                $display("FAIL rand_status @%0d: got lvl=%0d emp=%b rdy=%b rts_n=%b ov=%b irq=%b need lvl=%0d rts_n=%b ov=%b irq=%b",
                         i, bus.o_level, bus.o_empty, bus.o_wr_ready, bus.o_rts_n, bus.o_overrun, bus.o_irq,
                         m_q.size(), m_rts_n, m_ov, m_irq);
            end
        end
    endtask

    task automatic test_reset_mid();
        while (m_q.size() > 5) cycle(0, 8'h00, 1, 1, 0);
        while (m_q.size() < 5) cycle(1, 8'($urandom), 0, 1, 0);
        vectors++;
        if (bus.o_level !== 5'd5) begin
            miscompares++;
            $display("FAIL midrst_pre_level: got %0d need 5", bus.o_level);
        end
        @(negedge clk);
        bus.i_rx_dv = 1; bus.i_rx_byte = 8'h77; bus.i_rd_en = 1; bus.i_irq_en = 1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if ({bus.o_level, bus.o_empty, bus.o_rts_n, bus.o_irq, bus.o_overrun} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL midrst_now: got lvl=%0d emp=%b rts_n=%b irq=%b ov=%b need 0 1 0 0 0",
                     bus.o_level, bus.o_empty, bus.o_rts_n, bus.o_irq, bus.o_overrun);
        end
        @(negedge clk);
        bus.i_rx_dv = 0; bus.i_rd_en = 0; bus.i_irq_en = 0;
        rst_n = 1'b1;
        cycle(0, 8'h00, 0, 0, 0);
        vectors++;
        if ({bus.o_level, bus.o_empty} !== {5'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL midrst_after: got lvl=%0d emp=%b need 0 1", bus.o_level, bus.o_empty);
        end
        cycle(1, 8'hC3, 0, 0, 0);
        vectors++;
        if ({bus.o_level, bus.o_rd_data} !== {5'd1, 8'hC3}) begin
            miscompares++;
            $display("FAIL midrst_reuse: got lvl=%0d rd=%h need 1 c3", bus.o_level, bus.o_rd_data);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_order();
        test_rts();
        test_overrun_full();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
